// File: rtl/display_mode_sequencer_if.sv
// Key/frame inputs and committed mode/threshold outputs between the
// display mode sequencer and its neighbours.
interface display_mode_sequencer_if;
    logic       iFval;
    logic       iKeyNext;
    logic       iKeyPrev;
    logic       iThreshUp;
    logic       iThreshDown;
    logic       iAutoEn;
    logic [2:0] oSelect;
    logic [7:0] oThresholdLevel;
    logic       oBlank;
    logic       oModeChanged;
    logic       oFrameEnd;

    modport slave (
        input  iFval, iKeyNext, iKeyPrev, iThreshUp, iThreshDown, iAutoEn,
        output oSelect, oThresholdLevel, oBlank, oModeChanged, oFrameEnd
    );

    modport master (
        output iFval, iKeyNext, iKeyPrev, iThreshUp, iThreshDown, iAutoEn,
        input  oSelect, oThresholdLevel, oBlank, oModeChanged, oFrameEnd
    );
endinterface

// File: rtl/display_mode_sequencer.sv
// Mode select / threshold sequencer: key and auto-cycle requests are committed
// only in vertical blanking, followed by a programmable number of blanked frames.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no request outstanding; auto-cycle frame counter may run
// PENDING  | target mode requested, waiting for iFval low to commit
// BLANKING | oBlank high, counting frame ends; keys queue a new request
module display_mode_sequencer #(
    parameter int NUM_MODES    = 5,
    parameter int AUTO_FRAMES  = 60,
    parameter int BLANK_FRAMES = 2,
    parameter int THRESH_STEP  = 8,
    parameter int THRESH_INIT  = 128
) (
    input  logic                        iClk,
    input  logic                        iRst_n,
    display_mode_sequencer_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, PENDING, BLANKING} state_t;

    localparam logic [15:0] AUTO_LAST = 16'(AUTO_FRAMES - 1);
    localparam logic [7:0]  BLANK_N   = 8'(BLANK_FRAMES);
    localparam logic [7:0]  STEP8     = 8'(THRESH_STEP);

    state_t      state_q, state_d;
    logic        fval_q;
    logic [2:0]  sel_q, sel_d;
    logic [2:0]  target_q, target_d;
    logic        pending_q, pending_d;
    logic [7:0]  blank_cnt_q, blank_cnt_d;
    logic [15:0] auto_cnt_q, auto_cnt_d;
    logic [7:0]  shadow_q, shadow_d;
    logic [7:0]  thresh_q, thresh_d;
    logic        mode_changed_q, mode_changed_d;
    logic        frame_end_q;

    logic        frame_end, key_next, key_prev, key_any, auto_fire, advance, fwd;
    logic        commit;
    logic [2:0]  pend_tgt;
    logic [8:0]  thr_sum;
    logic [7:0]  thr_up, thr_dn;

    function automatic logic [2:0] step_mode(input logic [2:0] x, input logic dir_fwd);
        if (dir_fwd)
            return (x == 3'(NUM_MODES)) ? 3'd1 : x + 3'd1;
        else
            return (x == 3'd1) ? 3'(NUM_MODES) : x - 3'd1;
    endfunction

    assign frame_end = fval_q & ~bus.iFval;
    assign key_next  = bus.iKeyNext & ~bus.iKeyPrev;
    assign key_prev  = bus.iKeyPrev & ~bus.iKeyNext;
    assign key_any   = key_next | key_prev;
    // A manual key in the same cycle wins over the auto advance.
    assign auto_fire = (state_q == IDLE) & bus.iAutoEn & frame_end
                     & (auto_cnt_q == AUTO_LAST) & ~key_any;
    assign advance   = key_any | auto_fire;
    assign fwd       = ~key_prev;
    assign pend_tgt  = key_any ? step_mode(target_q, fwd) : target_q;

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state_q        <= IDLE;
            fval_q         <= 1'b0;
            sel_q          <= 3'd1;
            target_q       <= 3'd1;
            pending_q      <= 1'b0;
            blank_cnt_q    <= 8'd0;
            auto_cnt_q     <= 16'd0;
            shadow_q       <= 8'(THRESH_INIT);
            thresh_q       <= 8'(THRESH_INIT);
            mode_changed_q <= 1'b0;
            frame_end_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            fval_q         <= bus.iFval;
            sel_q          <= sel_d;
            target_q       <= target_d;
            pending_q      <= pending_d;
            blank_cnt_q    <= blank_cnt_d;
            auto_cnt_q     <= auto_cnt_d;
            shadow_q       <= shadow_d;
            thresh_q       <= thresh_d;
            mode_changed_q <= mode_changed_d;
            frame_end_q    <= frame_end;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        target_d    = target_q;
        pending_d   = pending_q;
        blank_cnt_d = blank_cnt_q;
        commit      = 1'b0;
        case (state_q)
            IDLE: begin
                if (advance) begin
                    target_d = step_mode(sel_q, fwd);
                    state_d  = PENDING;
                end
            end
            PENDING: begin
                target_d = pend_tgt;
                if (!bus.iFval) begin
                    if (pend_tgt != sel_q) begin
                        sel_d       = pend_tgt;
                        commit      = 1'b1;
                        blank_cnt_d = BLANK_N;
                        state_d     = (BLANK_FRAMES == 0) ? IDLE : BLANKING;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            BLANKING: begin
                if (key_any) begin
                    target_d  = step_mode(pending_q ? target_q : sel_q, fwd);
                    pending_d = 1'b1;
                end
                if (frame_end) begin
                    if (blank_cnt_q <= 8'd1) begin
                        blank_cnt_d = 8'd0;
                        state_d     = (pending_q | key_any) ? PENDING : IDLE;
                        pending_d   = 1'b0;
                    end else begin
                        blank_cnt_d = blank_cnt_q - 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        auto_cnt_d = auto_cnt_q;
        if (!bus.iAutoEn || key_any || commit || auto_fire)
            auto_cnt_d = 16'd0;
        else if (frame_end && state_q == IDLE)
            auto_cnt_d = auto_cnt_q + 16'd1;
    end

    // Threshold shadow saturates in 9 bits; the visible level only follows it in blanking.
    always_comb begin
        thr_sum  = {1'b0, shadow_q} + {1'b0, STEP8};
        thr_up   = thr_sum[8] ? 8'hFF : thr_sum[7:0];
        thr_dn   = (shadow_q < STEP8) ? 8'd0 : shadow_q - STEP8;
        shadow_d = shadow_q;
        if (bus.iThreshUp && !bus.iThreshDown)
            shadow_d = thr_up;
        else if (bus.iThreshDown && !bus.iThreshUp)
            shadow_d = thr_dn;
        thresh_d = bus.iFval ? thresh_q : shadow_q;
    end

    always_comb begin
        mode_changed_d      = commit;
        bus.oSelect         = sel_q;
        bus.oThresholdLevel = thresh_q;
        bus.oBlank          = (state_q == BLANKING);
        bus.oModeChanged    = mode_changed_q;
        bus.oFrameEnd       = frame_end_q;
    end
endmodule

// File: tb/tb_display_mode_sequencer.sv
// Directed bench for display_mode_sequencer: expected commits go into a queue
// and a monitor checks them against every oModeChanged pulse.
module tb_display_mode_sequencer;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   exp_q[$];

    display_mode_sequencer_if bus();

    display_mode_sequencer #(
        .NUM_MODES(5), .AUTO_FRAMES(3), .BLANK_FRAMES(2),
        .THRESH_STEP(8), .THRESH_INIT(128)
    ) dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic key(input bit nxt, input bit prv, input bit up, input bit dn);
        bus.iKeyNext    = nxt;
        bus.iKeyPrev    = prv;
        bus.iThreshUp   = up;
        bus.iThreshDown = dn;
        tick(1);
        bus.iKeyNext    = 1'b0;
        bus.iKeyPrev    = 1'b0;
        bus.iThreshUp   = 1'b0;
        bus.iThreshDown = 1'b0;
    endtask

    task automatic frame(input int act, input int gap);
        bus.iFval = 1'b1;
        tick(act);
        bus.iFval = 1'b0;
        tick(gap);
    endtask

    task automatic press_in_frame(input bit nxt, input bit prv, input int n);
        bus.iFval = 1'b1;
        tick(3);
        repeat (n) begin
            key(nxt, prv, 1'b0, 1'b0);
            tick(1);
        end
        tick(3);
        bus.iFval = 1'b0;
        tick(10);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && bus.oModeChanged) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_commit: got select %0d, expected no commit (t=%0t)",
                         bus.oSelect, $time);
            end else begin
                chk("commit_select", int'(bus.oSelect), exp_q.pop_front());
                chk("commit_blank", int'(bus.oBlank), 1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.iFval = 1'b0; bus.iKeyNext = 1'b0; bus.iKeyPrev = 1'b0;
        bus.iThreshUp = 1'b0; bus.iThreshDown = 1'b0; bus.iAutoEn = 1'b0;
        tick(3);
        chk("rst_select", int'(bus.oSelect), 1);
        chk("rst_thresh", int'(bus.oThresholdLevel), 128);
        chk("rst_blank", int'(bus.oBlank), 0);
        chk("rst_mode_changed", int'(bus.oModeChanged), 0);
        chk("rst_frame_end", int'(bus.oFrameEnd), 0);
        rst_n = 1'b1;
        tick(2);

        // Key during a frame commits in blanking, then two blanked frames
        bus.iFval = 1'b1;
        tick(5);
        exp_q.push_back(2);
        key(1, 0, 0, 0);
        tick(10);
        chk("hold_during_frame", int'(bus.oSelect), 1);
        fork
            begin
                bus.iFval = 1'b0;
                tick(10);
                repeat (3) frame(20, 10);
            end
            begin
                int fe_cnt = 0;
                bit seen = 0;
                for (int i = 0; i < 50 && !seen; i++) begin
                    @(negedge clk);
                    if (bus.oModeChanged) seen = 1;
                end
                chk("commit_seen", int'(seen), 1);
                if (seen) begin
                    bit done = 0;
                    for (int i = 0; i < 300 && !done; i++) begin
                        @(negedge clk);
                        if (bus.oFrameEnd) fe_cnt++;
                        if (!bus.oBlank) done = 1;
                    end
                    chk("blank_ended", int'(done), 1);
                    chk("blank_frame_ends", fe_cnt, 2);
                end
            end
        join
        chk("after_blank_select", int'(bus.oSelect), 2);

        // Accumulate to 5, wrap to 1 with iFval low, then three prevs to 3
        exp_q.push_back(5);
        press_in_frame(1, 0, 3);
        chk("accum_select", int'(bus.oSelect), 5);
        repeat (2) frame(20, 10);
        chk("blank_idle", int'(bus.oBlank), 0);
        exp_q.push_back(1);
        key(1, 0, 0, 0);
        chk("latency_not_yet", int'(bus.oSelect), 5);
        tick(1);
        chk("wrap_next_select", int'(bus.oSelect), 1);
        repeat (2) frame(20, 10);
        exp_q.push_back(3);
        press_in_frame(0, 1, 3);
        chk("prev_wrap_select", int'(bus.oSelect), 3);
        repeat (2) frame(20, 10);

        // Simultaneous keys ignored; next+prev in one frame resolves with no commit
        key(1, 1, 0, 0);
        tick(5);
        chk("both_keys_select", int'(bus.oSelect), 3);
        chk("both_keys_blank", int'(bus.oBlank), 0);
        bus.iFval = 1'b1;
        tick(3);
        key(1, 0, 0, 0);
        tick(1);
        key(0, 1, 0, 0);
        tick(3);
        bus.iFval = 1'b0;
        tick(10);
        chk("cancel_select", int'(bus.oSelect), 3);
        chk("cancel_blank", int'(bus.oBlank), 0);

        // Auto-cycle every 3 frame ends plus 2 blanked frames
        bus.iAutoEn = 1'b1;
        exp_q.push_back(4);
        exp_q.push_back(5);
        repeat (2) frame(70, 30);
        chk("auto_before", int'(bus.oSelect), 3);
        frame(70, 30);
        chk("auto_first", int'(bus.oSelect), 4);
        repeat (4) frame(70, 30);
        chk("auto_hold", int'(bus.oSelect), 4);
        frame(70, 30);
        chk("auto_second", int'(bus.oSelect), 5);
        repeat (3) frame(70, 30);
        exp_q.push_back(4);
        bus.iFval = 1'b1;
        tick(30);
        key(0, 1, 0, 0);
        tick(39);
        bus.iFval = 1'b0;
        tick(30);
        chk("auto_manual_prev", int'(bus.oSelect), 4);
        repeat (4) frame(70, 30);
        chk("auto_restart_hold", int'(bus.oSelect), 4);
        exp_q.push_back(5);
        frame(70, 30);
        chk("auto_restart_fire", int'(bus.oSelect), 5);
        bus.iAutoEn = 1'b0;
        repeat (2) frame(70, 30);

        // Threshold saturation and hold during active frame
        bus.iFval = 1'b1;
        tick(2);
        repeat (8) begin key(0, 0, 1, 0); tick(1); end
        tick(2);
        chk("thresh_held", int'(bus.oThresholdLevel), 128);
        bus.iFval = 1'b0;
        tick(3);
        chk("thresh_up8", int'(bus.oThresholdLevel), 192);
        bus.iFval = 1'b1;
        repeat (8) begin key(0, 0, 1, 0); tick(1); end
        chk("thresh_held2", int'(bus.oThresholdLevel), 192);
        bus.iFval = 1'b0;
        tick(3);
        chk("thresh_sat", int'(bus.oThresholdLevel), 255);
        repeat (2) begin key(0, 0, 1, 0); tick(1); end
        tick(2);
        chk("thresh_sat_more", int'(bus.oThresholdLevel), 255);
        key(0, 0, 1, 1);
        tick(2);
        chk("thresh_both", int'(bus.oThresholdLevel), 255);
        repeat (16) begin key(0, 0, 0, 1); tick(1); end
        tick(2);
        chk("thresh_down16", int'(bus.oThresholdLevel), 127);
        repeat (17) begin key(0, 0, 0, 1); tick(1); end
        tick(2);
        chk("thresh_floor", int'(bus.oThresholdLevel), 0);

        // Reset during blanking with a pending key
        exp_q.push_back(2);
        press_in_frame(1, 0, 2);
        chk("pre_reset_select", int'(bus.oSelect), 2);
        chk("pre_reset_blank", int'(bus.oBlank), 1);
        bus.iFval = 1'b1;
        tick(3);
        key(1, 0, 0, 0);
        tick(3);
        rst_n = 1'b0;
        tick(1);
        chk("mid_rst_blank", int'(bus.oBlank), 0);
        chk("mid_rst_select", int'(bus.oSelect), 1);
        chk("mid_rst_thresh", int'(bus.oThresholdLevel), 128);
        rst_n = 1'b1;
        tick(5);
        repeat (3) frame(20, 10);
        chk("post_rst_select", int'(bus.oSelect), 1);
        chk("post_rst_blank", int'(bus.oBlank), 0);

        tick(5);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
